// File: rtl/op_mult_pkg.sv
// Shared types and helpers for the op_* arithmetic blocks.
package op_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } op_mult_state_e;

  // Helper operates on a fixed wide word; callers extend operands (WIDTH < ABS_W).
  localparam int unsigned ABS_W = 64;

  // Unsigned magnitude of a sign- or zero-extended operand.
  function automatic logic [ABS_W-1:0] abs_u(input logic [ABS_W-1:0] value,
                                             input logic             is_signed);
    return (is_signed && value[ABS_W-1]) ? (~value + ABS_W'(1)) : value;
  endfunction

endpackage

// File: rtl/op_mult_seq.sv
// Iterative shift-add multiplier, one product in flight, valid/ready on both sides.
// Signed operands are multiplied as magnitudes and the sign is applied at the end.
module op_mult_seq
  import op_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  op_mult_state_e   r_state;
  op_mult_state_e   w_state_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mult;
  logic [WIDTH-1:0] r_mcand;
  logic             r_neg;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_p;

  logic [ABS_W-1:0] w_a_ext;
  logic [ABS_W-1:0] w_b_ext;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_mult_next;
  logic [PW-1:0]    w_prod;
  logic             w_last;

  // Operand magnitudes and one shift-add step (carry of the adder kept in w_sum).
  always_comb begin
    w_a_ext     = {{(ABS_W-WIDTH){is_signed & a[WIDTH-1]}}, a};
    w_b_ext     = {{(ABS_W-WIDTH){is_signed & b[WIDTH-1]}}, b};
    w_a_mag     = WIDTH'(abs_u(w_a_ext, is_signed));
    w_b_mag     = WIDTH'(abs_u(w_b_ext, is_signed));
    w_sum       = {1'b0, r_acc} + (r_mult[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    w_acc_next  = w_sum[WIDTH:1];
    w_mult_next = {w_sum[0], r_mult[WIDTH-1:1]};
    w_prod      = {w_acc_next, w_mult_next};
    w_last      = (r_cnt == CW'(WIDTH - 1));
  end

  // Next state and handshake decode, all from the registered state.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_mult  <= '0;
      r_mcand <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand <= w_a_mag;
            r_mult  <= w_b_mag;
            r_acc   <= '0;
            r_neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_cnt   <= '0;
          end
        end
        BUSY: begin
          r_acc  <= w_acc_next;
          r_mult <= w_mult_next;
          r_cnt  <= r_cnt + CW'(1);
          // Final step lands the signed result so p is ready with out_valid.
          if (w_last) r_p <= r_neg ? (~w_prod + PW'(1)) : w_prod;
        end
        default: ;
      endcase
    end
  end

  assign p = r_p;

endmodule

// File: tb/tb_op_mult_seq.sv
// Bench for op_mult_seq: transaction-level model with a per-cycle compare, plus directed
// vectors with literal products and latencies.
module tb_op_mult_seq;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           is_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Model: idle / computing for W edges / holding the product until taken.
  bit             m_busy = 1'b0;
  bit             m_done = 1'b0;
  int             m_age  = 0;
  logic [2*W-1:0] m_exp  = '0;
  logic [2*W-1:0] m_p    = '0;

  op_mult_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    int sx;
    int sy;
    sx = s ? int'($signed(x)) : int'(x);
    sy = s ? int'($signed(y)) : int'(y);
    return (2*W)'(sx * sy);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_p    <= '0;
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else if (m_busy) begin
      if (m_age == int'(W) - 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_p    <= m_exp;
      end
      m_age <= m_age + 1;
    end else if (in_valid) begin
      m_busy <= 1'b1;
      m_age  <= 0;
      m_exp  <= ref_mul(a, b, is_signed);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_out_valid", 32'(out_valid), 32'(m_done));
      check("cyc_in_ready", 32'(in_ready), 32'(!(m_busy || m_done)));
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_p", 32'(p), 32'(m_p));
    end
  end

  // Start and end at #1 after a posedge with the block idle; leaves the product pending.
  task automatic run_mult(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic s, input logic [2*W-1:0] exp);
    int lat;
    check({name, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = xa;
    b         = xb;
    is_signed = s;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    a         = ~xa;
    b         = ~xb;
    is_signed = ~s;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 32'(W));
    check({name, "_p"}, 32'(p), 32'(exp));
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    run_mult("u255", 8'd255, 8'd255, 1'b0, 16'hFE01);  consume("u255");
    run_mult("s80x80", 8'h80, 8'h80, 1'b1, 16'h4000);  consume("s80x80");
    run_mult("s80x01", 8'h80, 8'h01, 1'b1, 16'hFF80);  consume("s80x01");
    run_mult("sm3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1);   consume("sm3x5");
    run_mult("s0xm7", 8'h00, 8'hF9, 1'b1, 16'h0000);   consume("s0xm7");
    run_mult("uFDx05", 8'hFD, 8'h05, 1'b0, 16'h04F1);  consume("uFDx05");

    // Backpressure with a competing request held on the input.
    run_mult("bp", 8'd12, 8'd11, 1'b0, 16'd132);
    in_valid = 1'b1;
    a        = 8'd1;
    b        = 8'd1;
    repeat (20) @(posedge clk);
    #1;
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_p", 32'(p), 32'd132);
    check("bp_hold_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_b2b_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_b2b_lat", 32'(lat), 32'(W));
    check("bp_b2b_p", 32'(p), 32'd1);
    consume("bp_b2b");

    // Reset during the third BUSY cycle.
    in_valid  = 1'b1;
    a         = 8'd100;
    b         = 8'd3;
    is_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rstmid_out_valid", 32'(out_valid), 32'd0);
    check("rstmid_p", 32'(p), 32'd0);
    check("rstmid_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("rstmid_no_stale", 32'(out_valid), 32'd0);
    check("rstmid_p_after", 32'(p), 32'd0);

    // Random traffic with output stalls; the per-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = W'($urandom);
      b         = W'($urandom);
      is_signed = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (W + 4) @(posedge clk);
    #1;
    check("drain_idle", 32'(in_ready), 32'd1);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
